// File: rtl/iir_pkg.sv
// Shared types and fixed-point constants for the IIR datapath.
// Arbiter state encoding plus Q2.14 operand and Q4.28 result widths.
package iir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_GAP,
        ST_DRAIN,
        ST_DONE
    } arb_state_t;

    localparam int Q_W    = 16;
    localparam int Q_FRAC = 14;
    localparam int ACC_W  = 32;

endpackage

// File: rtl/mac_share_arbiter_rr_pick.sv
// Cyclic priority picker: first set request at or after ptr.
// Returns a one-hot winner, its index and an any-request flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan N positions starting at ptr, wrapping once.
    always_comb begin
        int k;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!any && req[k]) begin
                any       = 1'b1;
                idx       = IW'(k);
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin owner of one accumulating MAC slice across N_REQ
// biquad sequencers: clear, issue terms, drain, hand back the sum.
module mac_share_arbiter
    import iir_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAC_LAT   = 2,
    parameter int MAX_TERMS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       term_valid,
    input  logic [N_REQ-1:0]       term_last,
    input  logic [N_REQ*Q_W-1:0]   term_a,
    input  logic [N_REQ*Q_W-1:0]   term_b,
    output logic [N_REQ-1:0]       term_ready,
    output logic [N_REQ-1:0]       grant,
    output logic [ACC_W-1:0]       result,
    output logic [N_REQ-1:0]       result_valid,
    output logic                   err_overflow,
    output logic [Q_W-1:0]         mac_a,
    output logic [Q_W-1:0]         mac_b,
    output logic                   mac_ce,
    output logic                   mac_clr,
    input  logic [ACC_W-1:0]       mac_result
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_TERMS + 1);
    localparam int DW = $clog2(MAC_LAT + 1);

    arb_state_t state, state_nx;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    next_ptr;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    dcnt;
    logic [N_REQ-1:0] pick_oh;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             accept;
    logic             last_term;
    logic             cap_hit;
    logic             abort;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign accept    = (state == ST_ISSUE) && term_valid[owner];
    assign last_term = term_last[owner];
    assign cap_hit   = (cnt == CW'(MAX_TERMS - 1));
    assign next_ptr  = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
    assign abort     = !req[owner] &&
                       (state inside {ST_CLEAR, ST_ISSUE, ST_GAP});

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next state, handshake and accumulator clear.
    always_comb begin
        state_nx   = state;
        term_ready = '0;
        mac_clr    = reset || (state == ST_CLEAR);
        if (state == ST_ISSUE) term_ready = term_valid & grant;
        unique case (state)
            ST_IDLE:  if (pick_any) state_nx = ST_CLEAR;
            ST_CLEAR: state_nx = abort ? ST_IDLE : ST_ISSUE;
            ST_ISSUE: begin
                if (abort)
                    state_nx = ST_IDLE;
                else if (accept)
                    state_nx = (last_term || cap_hit) ? ST_DRAIN : ST_GAP;
            end
            ST_GAP:   state_nx = abort ? ST_IDLE : ST_ISSUE;
            ST_DRAIN: if (dcnt == DW'(MAC_LAT - 1)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Ownership, operands, counters and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            owner        <= '0;
            grant        <= '0;
            result       <= '0;
            result_valid <= '0;
            err_overflow <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_ce       <= 1'b0;
            cnt          <= '0;
            dcnt         <= '0;
        end else begin
            mac_ce       <= accept;
            result_valid <= '0;
            if (state == ST_IDLE && pick_any) begin
                grant <= pick_oh;
                owner <= pick_idx;
            end
            if (state == ST_CLEAR) cnt <= '0;
            if (accept) begin
                mac_a <= term_a[owner*Q_W +: Q_W];
                mac_b <= term_b[owner*Q_W +: Q_W];
                cnt   <= cnt + CW'(1);
                if (cap_hit && !last_term) err_overflow <= 1'b1;
            end
            if (state == ST_DRAIN) dcnt <= dcnt + DW'(1);
            else                   dcnt <= '0;
            if (abort) begin
                grant  <= '0;
                rr_ptr <= next_ptr;
            end
            if (state == ST_DONE) begin
                result       <= mac_result;
                result_valid <= grant;
                grant        <= '0;
                rr_ptr       <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter with a behavioural MAC16:
// acc += a*b visible two cycles after mac_ce, zeroed by mac_clr.
module tb_mac_share_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   term_valid;
    logic [N-1:0]   term_last;
    logic [N*16-1:0] term_a;
    logic [N*16-1:0] term_b;
    logic [N-1:0]   term_ready;
    logic [N-1:0]   grant;
    logic [31:0]    result;
    logic [N-1:0]   result_valid;
    logic           err_overflow;
    logic [15:0]    mac_a;
    logic [15:0]    mac_b;
    logic           mac_ce;
    logic           mac_clr;
    logic [31:0]    mac_result;

    always #5 clk = ~clk;

    mac_share_arbiter #(
        .N_REQ     (4),
        .MAC_LAT   (2),
        .MAX_TERMS (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .term_valid   (term_valid),
        .term_last    (term_last),
        .term_a       (term_a),
        .term_b       (term_b),
        .term_ready   (term_ready),
        .grant        (grant),
        .result       (result),
        .result_valid (result_valid),
        .err_overflow (err_overflow),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_ce       (mac_ce),
        .mac_clr      (mac_clr),
        .mac_result   (mac_result)
    );

    logic signed [31:0] acc;
    logic signed [31:0] prod;
    logic               pv;

    // Two-stage accumulate model.
    always @(posedge clk) begin
        if (mac_clr) begin
            acc  <= '0;
            prod <= '0;
            pv   <= 1'b0;
        end else begin
            pv   <= mac_ce;
            prod <= $signed(mac_a) * $signed(mac_b);
            if (pv) acc <= acc + prod;
        end
    end
    assign mac_result = acc;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    logic [15:0] ta [N][16];
    logic [15:0] tb [N][16];
    int          tn [N];
    bit          use_last [N];
    int          pos [N];
    int          acc_total [N];
    int          jobs_want [N];
    int          jobs_done [N];
    int          cyc;
    int          n_clr;
    int          stall_left;
    int          stall_ce;
    int          stall_rdy;
    logic [N-1:0] prev_grant;
    int          ce_t [$];
    logic [N-1:0] gr_log [$];
    logic [N-1:0] rv_log [$];
    logic [N-1:0] g_at_rv [$];
    logic [31:0] res_log [$];

    task automatic clear_state();
        for (int i = 0; i < N; i++) begin
            tn[i] = 0; use_last[i] = 1'b1; pos[i] = 0;
            acc_total[i] = 0; jobs_want[i] = 1; jobs_done[i] = 0;
        end
        cyc = 0; n_clr = 0; stall_left = 0;
        stall_ce = 0; stall_rdy = 0; prev_grant = '0;
        ce_t.delete(); gr_log.delete(); rv_log.delete();
        g_at_rv.delete(); res_log.delete();
    endtask

    task automatic do_reset(input bit check);
        reset = 1'b1; req = '0;
        term_valid = '0; term_last = '0; term_a = '0; term_b = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (check) begin
            chk("rst_grant", 32'(grant), 0);
            chk("rst_rv", 32'(result_valid), 0);
            chk("rst_result", result, 0);
            chk("rst_ovf", 32'(err_overflow), 0);
            chk("rst_ce", 32'(mac_ce), 0);
            chk("rst_ab", {mac_a, mac_b}, 0);
            chk("rst_clr", 32'(mac_clr), 1);
            chk("rst_ready", 32'(term_ready), 0);
        end
        reset = 1'b0;
        clear_state();
    endtask

    task automatic set_term(input int i, input int k,
                            input logic [15:0] a, input logic [15:0] b);
        ta[i][k] = a;
        tb[i][k] = b;
    endtask

    task automatic cycle();
        logic [N-1:0] rdy;
        term_valid = '0;
        term_last  = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && grant[i] && pos[i] < tn[i] && stall_left == 0) begin
                term_valid[i] = 1'b1;
                term_a[16*i +: 16] = ta[i][pos[i]];
                term_b[16*i +: 16] = tb[i][pos[i]];
                term_last[i] = use_last[i] && (pos[i] == tn[i] - 1);
            end
        end
        #1;
        rdy = term_ready;
        if (stall_left > 0) stall_rdy += $countones(term_ready);
        @(posedge clk); #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rdy[i]) begin
                pos[i]++;
                acc_total[i]++;
            end
        end
        if (mac_ce) begin
            ce_t.push_back(cyc);
            if (stall_left > 0) stall_ce++;
        end
        if (stall_left > 0) stall_left--;
        if (mac_clr) n_clr++;
        if (grant != prev_grant && grant != '0) gr_log.push_back(grant);
        prev_grant = grant;
        if (|result_valid) begin
            rv_log.push_back(result_valid);
            res_log.push_back(result);
            g_at_rv.push_back(grant);
            for (int i = 0; i < N; i++) begin
                if (result_valid[i]) begin
                    pos[i] = 0;
                    jobs_done[i]++;
                    if (jobs_done[i] >= jobs_want[i]) req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run_to_rv(input int n, input int budget, input string tag);
        int k = 0;
        while (rv_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, rv_log.size(), n);
    endtask

    task automatic run_to_pos(input int i, input int p, input int budget,
                              input string tag);
        int k = 0;
        while (pos[i] < p && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, pos[i], p);
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic load_t1();
        tn[0] = 5;
        set_term(0, 0, 16'd16384, 16'd1000);
        set_term(0, 1, 16'd8192, 16'd2000);
        for (int k = 2; k < 5; k++) set_term(0, k, 16'd0, 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        clear_state();
        do_reset(1'b1);

        // single job, requester 0
        load_t1();
        req = 4'b0001;
        run_to_rv(1, 60, "t1_done");
        run_n(8);
        chk("t1_ce_cnt", ce_t.size(), 5);
        chk("t1_ce_gap", ce_t[1] - ce_t[0], 2);
        chk("t1_ce_span", ce_t[4] - ce_t[0], 8);
        chk("t1_result", res_log[0], 32'd32768000);
        chk("t1_rv", 32'(rv_log[0]), 32'b0001);
        chk("t1_rv_once", rv_log.size(), 1);
        chk("t1_grant_off", 32'(g_at_rv[0]), 0);
        chk("t1_clr", n_clr, 1);
        chk("t1_held", result, 32'd32768000);
        chk("t1_ovf", 32'(err_overflow), 0);

        // two contenders from rr_ptr 0
        do_reset(1'b0);
        tn[1] = 1; set_term(1, 0, 16'd2, 16'd3);
        tn[3] = 1; set_term(3, 0, 16'd4, 16'd5);
        req = 4'b1010;
        run_to_rv(2, 60, "t2_done");
        chk("t2_g0", 32'(gr_log[0]), 32'b0010);
        chk("t2_g1", 32'(gr_log[1]), 32'b1000);
        chk("t2_rv0", 32'(rv_log[0]), 32'b0010);
        chk("t2_rv1", 32'(rv_log[1]), 32'b1000);
        chk("t2_r0", res_log[0], 6);
        chk("t2_r1", res_log[1], 20);

        // all four requesting, 3-term jobs
        do_reset(1'b0);
        for (int i = 0; i < N; i++) begin
            tn[i] = 3;
            for (int k = 0; k < 3; k++)
                set_term(i, k, 16'(i + 1), 16'(k + 1));
        end
        jobs_want[0] = 2;
        req = 4'b1111;
        run_to_rv(5, 150, "t3_done");
        chk("t3_g0", 32'(gr_log[0]), 32'b0001);
        chk("t3_g1", 32'(gr_log[1]), 32'b0010);
        chk("t3_g2", 32'(gr_log[2]), 32'b0100);
        chk("t3_g3", 32'(gr_log[3]), 32'b1000);
        chk("t3_g4", 32'(gr_log[4]), 32'b0001);
        chk("t3_clr", n_clr, 5);
        chk("t3_r1", res_log[1], 12);
        chk("t3_r3", res_log[3], 24);
        chk("t3_r4", res_log[4], 6);

        // owner stalls three cycles mid-job
        do_reset(1'b0);
        load_t1();
        req = 4'b0001;
        run_to_pos(0, 2, 30, "t4_pos");
        stall_left = 3;
        run_to_rv(1, 60, "t4_done");
        chk("t4_stall_ce", stall_ce, 0);
        chk("t4_stall_rdy", stall_rdy, 0);
        chk("t4_ce_cnt", ce_t.size(), 5);
        chk("t4_result", res_log[0], 32'd32768000);

        // owner drops req after two terms
        do_reset(1'b0);
        tn[2] = 4;
        for (int k = 0; k < 4; k++) set_term(2, k, 16'd1, 16'd1);
        tn[3] = 1; set_term(3, 0, 16'd7, 16'd7);
        req = 4'b1100;
        run_to_pos(2, 2, 30, "t5_pos");
        req[2] = 1'b0;
        cycle();
        chk("t5_abort_g", 32'(grant), 0);
        run_to_rv(1, 60, "t5_done");
        run_n(4);
        chk("t5_g0", 32'(gr_log[0]), 32'b0100);
        chk("t5_g1", 32'(gr_log[1]), 32'b1000);
        chk("t5_rv_cnt", rv_log.size(), 1);
        chk("t5_rv", 32'(rv_log[0]), 32'b1000);
        chk("t5_result", res_log[0], 49);
        chk("t5_clr", n_clr, 2);

        // reset in the middle of a job
        tn[1] = 4;
        for (int k = 0; k < 4; k++) set_term(1, k, 16'd1, 16'd1);
        req = 4'b0010;
        run_to_pos(1, 1, 30, "t5_mid");
        do_reset(1'b1);

        // forced termination at MAX_TERMS
        tn[0] = 9;
        use_last[0] = 1'b0;
        for (int k = 0; k < 9; k++) set_term(0, k, 16'd1, 16'd1);
        req = 4'b0001;
        run_to_rv(1, 80, "t6_done");
        chk("t6_accepted", acc_total[0], 8);
        chk("t6_result", res_log[0], 8);
        chk("t6_ovf", 32'(err_overflow), 1);
        run_n(6);
        chk("t6_sticky", 32'(err_overflow), 1);
        do_reset(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
